// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Segment codes are active-low with bit6=a ... bit0=g.
package disp_pkg;

  typedef enum logic [1:0] {
    S_OFF,
    S_SHOW,
    S_GUARD
  } state_e;

  localparam int MAX_NDIG = 8;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // All anodes released; slice down to the instance's digit count.
  localparam logic [MAX_NDIG-1:0] AN_OFF = {MAX_NDIG{1'b1}};

  // Entry n is the glyph for hex digit n (listed F first, packed MSB first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Datapath/display-pin bundle of the scan controller; the controller is the slave side.
// No handshake: load is a one-cycle strobe that is always accepted.
interface disp_scan_ctrl_if #(
  parameter int NDIG = 4
);
  logic                enable;
  logic                load;
  logic [4*NDIG-1:0]   value_in;
  logic [NDIG-1:0]     an;
  logic [6:0]          seg;
  logic                frame_done;
  logic                pending;

  modport master (
    output enable, load, value_in,
    input  an, seg, frame_done, pending
  );

  modport slave (
    input  enable, load, value_in,
    output an, seg, frame_done, pending
  );
endinterface

// File: rtl/hex_seg_dec.sv
// Combinational hex nibble to active-low 7-segment decoder; zero latency, no flow control.
module hex_seg_dec
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed NDIG-digit 7-segment scanner with guard blanking and frame-aligned double buffering.
// an/seg registered (one edge after the decision); no backpressure. DISP_LZ_BLANK_EN enables leading-zero blanking.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int GUARD = 8
) (
  input  logic             clk,
  input  logic             rst,
  disp_scan_ctrl_if.slave  bus
);
  localparam int IW   = $clog2(NDIG);
  localparam int PMAX = (DIV > GUARD) ? DIV : GUARD;
  localparam int PW   = $clog2(PMAX);
  localparam int W    = 4 * NDIG;

  localparam logic [PW-1:0] DIV_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [W-1:0]    active_q, active_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic [NDIG-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            frame_done_q, frame_done_d;

  logic            boundary;
  logic            xfer;
  logic            lit;
  logic [3:0]      nib;
  logic [6:0]      dec_seg;

  always_comb begin
    boundary = bus.enable && (state_q == S_GUARD) && (presc_q == GUARD_LAST) &&
               (idx_q == IDX_LAST);
    // While dark there is no frame to tear, so buffered values go straight through.
    xfer = (state_q == S_OFF) || boundary;

    shadow_d  = bus.load ? bus.value_in : shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (xfer) begin
      if (bus.load) begin
        active_d = bus.value_in;
      end else if (pending_q) begin
        active_d = shadow_q;
      end
      pending_d = 1'b0;
    end else if (bus.load) begin
      pending_d = 1'b1;
    end

    state_d      = state_q;
    idx_d        = idx_q;
    presc_d      = presc_q;
    frame_done_d = 1'b0;
    if (!bus.enable) begin
      state_d = S_OFF;
      idx_d   = '0;
      presc_d = '0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_SHOW;
          idx_d   = '0;
          presc_d = '0;
        end
        S_SHOW: begin
          if (presc_q == DIV_LAST) begin
            state_d = S_GUARD;
            presc_d = '0;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_GUARD: begin
          if (presc_q == GUARD_LAST) begin
            state_d      = S_SHOW;
            presc_d      = '0;
            idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            frame_done_d = (idx_q == IDX_LAST);
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: begin
          state_d = S_OFF;
          idx_d   = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next-state values so they land on the same edge.
  always_comb begin
    nib = active_d[4*idx_d +: 4];
  end

  hex_seg_dec u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  always_comb begin
    lit = (state_d == S_SHOW);
`ifdef DISP_LZ_BLANK_EN
    if (idx_d != '0) begin
      logic all_zero;
      all_zero = 1'b1;
      for (int k = 1; k < NDIG; k++) begin
        if ((k >= int'(idx_d)) && (active_d[4*k +: 4] != 4'h0)) begin
          all_zero = 1'b0;
        end
      end
      if (all_zero) begin
        lit = 1'b0;
      end
    end
`endif
    an_d  = lit ? ~(NDIG'(1) << idx_d) : AN_OFF[NDIG-1:0];
    seg_d = lit ? dec_seg : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_OFF;
      idx_q        <= '0;
      presc_q      <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      an_q         <= AN_OFF[NDIG-1:0];
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      presc_q      <= presc_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Randomised bench for disp_scan_ctrl against a slot-arithmetic reference model.
module tb_disp_scan_ctrl;
  localparam int NDIG  = 4;
  localparam int DIV   = 4;
  localparam int GUARD = 2;
  localparam int SLOT  = DIV + GUARD;
  localparam int FRAME = NDIG * SLOT;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  disp_scan_ctrl_if #(.NDIG(NDIG)) bus ();

  disp_scan_ctrl #(
    .NDIG  (NDIG),
    .DIV   (DIV),
    .GUARD (GUARD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: display on/off, cycle position within the frame, buffers.
  bit          m_on;
  int          m_pos;
  logic [15:0] m_act;
  logic [15:0] m_sh;
  bit          m_pend;
  bit          m_fd;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic en, input logic ld, input logic [15:0] val, input logic r);
    logic       bnd;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic [3:0] nibv;
    bit         blank;
    int         dig;
    rst          = r;
    bus.enable   = en;
    bus.load     = ld;
    bus.value_in = val;
    @(posedge clk);
    if (r) begin
      m_on = 0; m_pos = 0; m_act = '0; m_sh = '0; m_pend = 0; m_fd = 0;
    end else begin
      bnd = m_on && en && (m_pos == FRAME - 1);
      if (ld) m_sh = val;
      if (!m_on || bnd) begin
        if (ld) m_act = val;
        else if (m_pend) m_act = m_sh;
        m_pend = 0;
      end else if (ld) begin
        m_pend = 1;
      end
      m_fd = bnd;
      if (!en) m_on = 0;
      else if (!m_on) begin m_on = 1; m_pos = 0; end
      else m_pos = (m_pos + 1) % FRAME;
    end
    #1;
    exp_an  = 4'hF;
    exp_seg = 7'b1111111;
    if (m_on && (m_pos % SLOT) < DIV) begin
      dig   = m_pos / SLOT;
      nibv  = 4'(m_act >> (4 * dig));
      blank = 0;
`ifdef DISP_LZ_BLANK_EN
      blank = (dig > 0) && ((m_act >> (4 * dig)) == 16'h0);
`endif
      if (!blank) begin
        exp_an  = ~(4'b0001 << dig);
        exp_seg = seg_ref(nibv);
      end
    end
    chk("an", 32'(bus.an), 32'(exp_an));
    chk("seg", 32'(bus.seg), 32'(exp_seg));
    chk("frame_done", 32'(bus.frame_done), 32'(m_fd));
    chk("pending", 32'(bus.pending), 32'(m_pend));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  // Advance with enable high until the model sits at frame position p.
  task automatic goto_pos(input int p);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_on && m_pos == p) break;
      step(1'b1, 1'b0, 16'h0, 1'b0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.load = 1'b0;
    bus.value_in = '0;

    step(1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    run(2 * FRAME + 3);

    goto_pos(9);
    step(1'b1, 1'b1, 16'h1A2F, 1'b0);
    run(FRAME + 6);

    goto_pos(3);
    step(1'b1, 1'b1, 16'h1111, 1'b0);
    run(4);
    step(1'b1, 1'b1, 16'h2222, 1'b0);
    run(FRAME + 4);

    goto_pos(FRAME - 1);
    step(1'b1, 1'b1, 16'h00C3, 1'b0);
    run(FRAME);

    goto_pos(2 * SLOT + 1);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    run(SLOT + 2);

    goto_pos(5);
    step(1'b1, 1'b1, 16'h0005, 1'b0);
    run(FRAME + 2);
    step(1'b1, 1'b1, 16'h0000, 1'b0);
    run(2 * FRAME);

    // Load while dark, then enable on the very next edge.
    step(1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 16'hBEEF, 1'b0);
    run(SLOT);
    step(1'b0, 1'b1, 16'h4D3C, 1'b0);
    run(SLOT);

    // Reset mid-scan drops a pending value.
    goto_pos(7);
    step(1'b1, 1'b1, 16'h7777, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b1);
    run(FRAME + 2);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 49) != 0),
           ($urandom_range(0, 9) == 0),
           16'($urandom),
           ($urandom_range(0, 499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
